axi_write_slave: RTL and testbench

AXI_WRITE_SLAVE -- requirements
Module: axi_write_slave

---
 rtl/axi_wr_pkg.sv | 27 ++
 rtl/axi_burst_addr_gen.sv | 39 +++
 rtl/axi_write_slave.sv | 129 ++++++++++++
 tb/tb_axi_write_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// Shared types and encodings for the AXI write slave and its address generator.
// Also holds the AW legality rule used by both.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StResp
  } wr_state_e;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // Reserved burst type, oversize beats, or a WRAP length the container math cannot handle.
  function automatic logic aw_illegal(input logic [2:0] size, input logic [7:0] len,
                                      input logic [1:0] burst, input logic [2:0] max_size);
    logic bad_wrap;
    bad_wrap = (burst == BurstWrap) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    return (burst == 2'b11) || (size > max_size) || bad_wrap;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Computes the byte address of the next beat of an AXI burst from the current one.
// Illegal burst parameters fall back to INCR with the beat size clamped to the bus width.
module axi_burst_addr_gen
  import axi_wr_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned MaxSize = 3
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  localparam logic [2:0] MaxSizeL = 3'(MaxSize);

  logic [2:0]    eff_size;
  logic [AW-1:0] step;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;

  always_comb begin
    eff_size  = (size > MaxSizeL) ? MaxSizeL : size;
    step      = AW'(1) << eff_size;
    incr_addr = addr + step;
    // Container is (len+1) beats, a power of two for every legal WRAP length.
    wrap_mask = ((AW'(len) + AW'(1)) << eff_size) - AW'(1);
    next_addr = incr_addr;
    if (!aw_illegal(size, len, burst, MaxSizeL)) begin
      case (burst)
        BurstFixed: next_addr = addr;
        BurstWrap:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        default:    next_addr = incr_addr;
      endcase
    end
  end

endmodule

// File: rtl/axi_write_slave.sv
// AXI write slave handling one burst at a time; each accepted beat becomes a registered
// single-cycle memory write, and the burst ends with a B response.
module axi_write_slave
  import axi_wr_pkg::*;
#(
  parameter int unsigned IDW = 12,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDW-1:0]    s_axi_awid,
  input  logic [AW-1:0]     s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DW-1:0]     s_axi_wdata,
  input  logic [DW/8-1:0]   s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [IDW-1:0]    s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wstrb
);

  localparam int unsigned MaxSize  = $clog2(DW / 8);
  localparam logic [2:0]  MaxSizeL = 3'(MaxSize);

  wr_state_e      state_q, state_d;
  logic [IDW-1:0] id_q;
  logic [AW-1:0]  addr_q;
  logic [AW-1:0]  next_addr;
  logic [7:0]     len_q;
  logic [7:0]     cnt_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic           err_q;
  logic           aw_hs;
  logic           w_hs;
  logic           last_beat;

  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_hs      = s_axi_wvalid & s_axi_wready;
  assign last_beat = (cnt_q == len_q);

  // Response fields read as zero while reset is held.
  assign s_axi_bid   = rst ? '0 : id_q;
  assign s_axi_bresp = (err_q && !rst) ? RespSlverr : RespOkay;

  axi_burst_addr_gen #(
    .AW      (AW),
    .MaxSize (MaxSize)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_comb begin
    state_d       = state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_axi_awready = !rst;
        if (aw_hs) state_d = StData;
      end
      StData: begin
        s_axi_wready = !rst;
        if (w_hs && last_beat) state_d = StResp;
      end
      StResp: begin
        s_axi_bvalid = !rst;
        if (s_axi_bvalid && s_axi_bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state_q <= state_d;
      mem_we  <= w_hs;
      if (aw_hs) begin
        id_q    <= s_axi_awid;
        addr_q  <= s_axi_awaddr;
        len_q   <= s_axi_awlen;
        size_q  <= s_axi_awsize;
        burst_q <= s_axi_awburst;
        cnt_q   <= '0;
        err_q   <= aw_illegal(s_axi_awsize, s_axi_awlen, s_axi_awburst, MaxSizeL);
      end
      if (w_hs) begin
        mem_addr  <= addr_q;
        mem_wdata <= s_axi_wdata;
        mem_wstrb <= s_axi_wstrb;
        addr_q    <= next_addr;
        // Count saturates at awlen; the FSM leaves DATA on that beat regardless of wlast.
        if (!last_beat) cnt_q <= cnt_q + 8'd1;
        if (s_axi_wlast != last_beat) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_write_slave.sv
// Randomized bench for axi_write_slave: directed bursts plus random ones, with beat
// addresses and responses predicted by a closed-form burst model.
module tb_axi_write_slave;

  localparam int IDW = 12;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IDW-1:0]  s_axi_awid = '0;
  logic [AW-1:0]   s_axi_awaddr = '0;
  logic [7:0]      s_axi_awlen = '0;
  logic [2:0]      s_axi_awsize = '0;
  logic [1:0]      s_axi_awburst = '0;
  logic            s_axi_awvalid = 1'b0;
  logic            s_axi_awready;
  logic [DW-1:0]   s_axi_wdata = '0;
  logic [DW/8-1:0] s_axi_wstrb = '0;
  logic            s_axi_wlast = 1'b0;
  logic            s_axi_wvalid = 1'b0;
  logic            s_axi_wready;
  logic [IDW-1:0]  s_axi_bid;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready = 1'b0;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;

  always #5 clk = ~clk;

  axi_write_slave #(
    .IDW (IDW),
    .AW  (AW),
    .DW  (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb)
  );

  typedef struct {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
  } beat_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  beat_t       exp_q[$];
  beat_t       mon_e;

  logic [AW-1:0] cur_addr;
  logic [7:0]    cur_len;
  logic [2:0]    cur_size;
  logic [1:0]    cur_burst;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_bad(input logic [2:0] size, input logic [7:0] len,
                                input logic [1:0] burst);
    return (burst == 2'b11) || (size > 3'd3) ||
           ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Address of beat i, from the burst definition rather than step-by-step accumulation.
  function automatic logic [AW-1:0] model_addr(input int i);
    int unsigned   s;
    logic [AW-1:0] stride, c, base;
    s      = (cur_size > 3'd3) ? 3 : int'(cur_size);
    stride = 32'(i) << s;
    if (is_bad(cur_size, cur_len, cur_burst)) return cur_addr + stride;
    case (cur_burst)
      2'b00:   return cur_addr;
      2'b01:   return cur_addr + stride;
      default: begin
        c    = (32'(cur_len) + 32'd1) << s;
        base = cur_addr - (cur_addr % c);
        return base + ((cur_addr - base + stride) % c);
      end
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_we", 64'(mem_we), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("mem_addr", 64'(mem_addr), 64'(mon_e.addr));
        check_eq("mem_wdata", mem_wdata, mon_e.data);
        check_eq("mem_wstrb", 64'(mem_wstrb), 64'(mon_e.strb));
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic aw_send(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    check_eq("w_idle", 64'(s_axi_wready), 64'd0);
    s_axi_awid    = id;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awsize  = size;
    s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    cur_addr      = addr;
    cur_len       = len;
    cur_size      = size;
    cur_burst     = burst;
    while (!s_axi_awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("aw_ready", 64'(s_axi_awready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    check_eq("w_after_aw", 64'(s_axi_wready), 64'd1);
    check_eq("aw_busy", 64'(s_axi_awready), 64'd0);
  endtask

  task automatic w_beat(input int i, input int wlast_beat);
    int n = 0;
    beat_t b;
    if ($urandom_range(0, 2) == 0) begin
      s_axi_wvalid = 1'b0;
      @(negedge clk);
    end
    s_axi_wdata  = {$urandom, $urandom};
    s_axi_wstrb  = 8'($urandom);
    s_axi_wlast  = (i == wlast_beat);
    s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("w_ready", 64'(s_axi_wready), 64'd1);
    check_eq("aw_blocked", 64'(s_axi_awready), 64'd0);
    b.addr = model_addr(i);
    b.data = s_axi_wdata;
    b.strb = s_axi_wstrb;
    exp_q.push_back(b);
    @(posedge clk);
    @(negedge clk);
    check_eq("we_lat", 64'(mem_we), 64'd1);
  endtask

  task automatic b_recv(input logic [IDW-1:0] id, input logic [1:0] resp, input int hold,
                        input bit noise);
    int n = 0;
    s_axi_bready = 1'b0;
    while (!s_axi_bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("bvalid", 64'(s_axi_bvalid), 64'd1);
    check_eq("bid", 64'(s_axi_bid), 64'(id));
    check_eq("bresp", 64'(s_axi_bresp), 64'(resp));
    if (noise) begin
      s_axi_awvalid = 1'b1;
      s_axi_awid    = 12'($urandom);
    end
    repeat (hold) begin
      @(negedge clk);
      check_eq("hold_bvalid", 64'(s_axi_bvalid), 64'd1);
      check_eq("hold_bid", 64'(s_axi_bid), 64'(id));
      check_eq("hold_bresp", 64'(s_axi_bresp), 64'(resp));
      check_eq("hold_awready", 64'(s_axi_awready), 64'd0);
    end
    s_axi_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axi_bready  = 1'b0;
    s_axi_awvalid = 1'b0;
    check_eq("b_done", 64'(s_axi_bvalid), 64'd0);
    check_eq("aw_reopen", 64'(s_axi_awready), 64'd1);
  endtask

  task automatic run_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int wlast_beat, input int hold,
                           input bit noise);
    logic [1:0] resp;
    aw_send(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) w_beat(i, wlast_beat);
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    resp = (is_bad(size, len, burst) || wlast_beat != int'(len)) ? 2'b10 : 2'b00;
    b_recv(id, resp, hold, noise);
  endtask

  initial begin
    logic [7:0] len;
    int         wl;

    repeat (3) @(negedge clk);
    check_eq("rst_awready", 64'(s_axi_awready), 64'd0);
    check_eq("rst_wready", 64'(s_axi_wready), 64'd0);
    check_eq("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check_eq("rst_we", 64'(mem_we), 64'd0);
    check_eq("rst_bid", 64'(s_axi_bid), 64'd0);
    check_eq("rst_bresp", 64'(s_axi_bresp), 64'd0);
    check_eq("rst_maddr", 64'(mem_addr), 64'd0);
    check_eq("rst_mdata", mem_wdata, 64'd0);
    check_eq("rst_mstrb", 64'(mem_wstrb), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_awready", 64'(s_axi_awready), 64'd1);

    run_burst(12'h5a3, 32'h100, 8'd3, 3'd3, 2'b01, 3, 0, 1'b0);
    run_burst(12'h0c1, 32'h118, 8'd3, 3'd3, 2'b10, 3, 1, 1'b0);
    run_burst(12'h222, 32'h40, 8'd2, 3'd3, 2'b00, 2, 0, 1'b0);
    run_burst(12'h3f0, 32'h300, 8'd3, 3'd3, 2'b01, 1, 0, 1'b0);
    run_burst(12'habc, 32'h80, 8'd1, 3'd2, 2'b01, 1, 5, 1'b1);

    // Reset after beat 1 of a 4-beat burst must abort it silently.
    aw_send(12'h077, 32'h200, 8'd3, 3'd3, 2'b01);
    w_beat(0, 3);
    w_beat(1, 3);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_we", 64'(mem_we), 64'd0);
    check_eq("abort_wready", 64'(s_axi_wready), 64'd0);
    check_eq("abort_bvalid", 64'(s_axi_bvalid), 64'd0);
    check_eq("abort_awready", 64'(s_axi_awready), 64'd0);
    rst          = 1'b0;
    s_axi_wvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("abort_no_b", 64'(s_axi_bvalid), 64'd0);
      check_eq("abort_no_we", 64'(mem_we), 64'd0);
    end
    check_eq("abort_awready_back", 64'(s_axi_awready), 64'd1);
    run_burst(12'h078, 32'h1000, 8'd3, 3'd2, 2'b01, 3, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      len = ($urandom_range(0, 3) == 0) ? 8'd15 : 8'($urandom_range(0, 7));
      wl  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len) + 1)) : int'(len);
      run_burst(12'($urandom), $urandom, len,
                ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                            : 3'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), wl, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check_eq("pending_beats", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
